// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, default bus widths and the
// instruction byte-sequencer state encoding.
package cpu_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 13;

    localparam logic [2:0] OP_HLT  = 3'b000;
    localparam logic [2:0] OP_SKZ  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_ANDD = 3'b011;
    localparam logic [2:0] OP_XORR = 3'b100;
    localparam logic [2:0] OP_LDA  = 3'b101;
    localparam logic [2:0] OP_STO  = 3'b110;
    localparam logic [2:0] OP_JMP  = 3'b111;

    // HI: the next captured byte is the opcode/high-address byte.
    typedef enum logic {
        HI = 1'b0,
        LO = 1'b1
    } byte_state_e;

endpackage

// File: rtl/program_counter.sv
// Program counter register: a load from the instruction operand takes
// priority over increment, and the increment wraps at 2^ADDR_W.
module program_counter
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int PC_RESET = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              inc_i,
    input  logic [ADDR_W-1:0] load_val_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= ADDR_W'(PC_RESET);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch datapath: assembles a two-byte instruction from the
// data bus, holds the PC and muxes the memory address.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int PC_RESET = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              inc_pc,
    input  logic              load_pc,
    input  logic              load_ir,
    input  logic              fetch,
    input  logic [DATA_W-1:0] data,
    output logic [2:0]        opcode,
    output logic [ADDR_W-1:0] ir_addr,
    output logic [ADDR_W-1:0] pc_addr,
    output logic [ADDR_W-1:0] addr,
    output logic              byte_sel,
    output logic              ir_valid
);

    byte_state_e         state_q;
    logic [2*DATA_W-1:0] ir_q;
    logic                ir_valid_q;

    // Disabled CPU freezes the IR and PC; only the sequencer is cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HI;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
        end else if (!ena) begin
            state_q    <= HI;
            ir_valid_q <= 1'b0;
        end else if (load_ir) begin
            case (state_q)
                HI: begin
                    ir_q[2*DATA_W-1:DATA_W] <= data;
                    ir_valid_q              <= 1'b0;
                    state_q                 <= LO;
                end
                LO: begin
                    ir_q[DATA_W-1:0] <= data;
                    ir_valid_q       <= 1'b1;
                    state_q          <= HI;
                end
                default: state_q <= HI;
            endcase
        end
    end

    // The PC loads the operand as registered before this edge's IR write.
    program_counter #(
        .ADDR_W   (ADDR_W),
        .PC_RESET (PC_RESET)
    ) u_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (ena & load_pc),
        .inc_i      (ena & inc_pc),
        .load_val_i (ir_addr),
        .pc_o       (pc_addr)
    );

    assign opcode   = ir_q[2*DATA_W-1 -: 3];
    assign ir_addr  = ir_q[ADDR_W-1:0];
    assign addr     = fetch ? pc_addr : ir_addr;
    assign byte_sel = state_q;
    assign ir_valid = ir_valid_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch datapath directly downstream of the CPU control state machine.
- Consumes the machine's inc_pc, load_pc and load_ir strobes; assembles the 16-bit instruction from two consecutive 8-bit bus reads; holds the program counter.
- Returns opcode to the state machine; drives the memory address mux (PC during fetch, instruction operand otherwise).

Parameters:
- DATA_W, 8, data bus width; instruction register is 2*DATA_W bits.
- ADDR_W, 13, address width; must equal 2*DATA_W-3.
- PC_RESET, 0, program counter value after reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge (control strobes launch on falling edge).
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  CPU run enable; low = synchronous clear of the byte sequencer and ir_valid.
- inc_pc  input  1  increment PC.
- load_pc  input  1  load PC from ir_addr.
- load_ir  input  1  capture one instruction byte from data.
- fetch  input  1  address mux select: 1 = pc_addr, 0 = ir_addr.
- data  input  DATA_W  memory read data bus.
- opcode  output  3  ir[15:13].
- ir_addr  output  ADDR_W  ir[12:0].
- pc_addr  output  ADDR_W  current PC.
- addr  output  ADDR_W  memory address = fetch ? pc_addr : ir_addr (combinational).
- byte_sel  output  1  0 = next load_ir writes the high byte; 1 = it writes the low byte.
- ir_valid  output  1  both bytes of the current instruction captured.

Behaviour:
- Reset (rst_n low, asynchronous): ir=0 (so opcode=0, ir_addr=0), pc=PC_RESET, byte_sel=0, ir_valid=0. addr follows fetch combinationally, even during reset.
- Clock and reset are fixed as decided: one clock, asynchronous active-low reset.
- ena low at a rising edge: byte_sel<=0, ir_valid<=0; ir and pc hold. load_ir, inc_pc and load_pc are ignored.
- Byte sequencer (2 states: HI, LO; byte_sel = state):
  - HI + load_ir: ir[15:8]<=data, ir_valid<=0, go to LO.
  - LO + load_ir: ir[7:0]<=data, ir_valid<=1, go to HI.
  - No load_ir: hold state.
- Latency: opcode and ir_addr update the cycle after the capturing edge. opcode is valid one rising edge after the HI capture, in time for the state machine's opcode decode two states later.
- PC update (priority order):
  - load_pc: pc<=ir_addr, using the registered value before this edge's IR update.
  - else inc_pc: pc<=pc+1 modulo 2^ADDR_W; 8191 wraps to 0.
  - load_pc and inc_pc together: load_pc wins.
- inc_pc and load_ir are independent and may coincide (the machine's state 001 does this). Both take effect at the same edge.
- load_pc while byte_sel=1: loads the mixed ir_addr (new high bits, old low bits). Legal and unchecked; the controller must not do this.
- Reset mid-instruction: sequencer returns to HI immediately and the partial instruction is discarded.
- No X propagation: all registers reset; addr is a pure 2:1 mux.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants HLT=000, SKZ=001, ADD=010, ANDD=011, XORR=100, LDA=101, STO=110, JMP=111.
  - DATA_W and ADDR_W defaults.
  - byte_sel state encoding HI=0, LO=1.
- One sub-module: program_counter (pc register with load/increment priority and wrap).
- The IR, sequencer and address mux stay in fetch_unit.

Test Plan:
- Reset: rst_n=0 with fetch=1 -> pc_addr=0, addr=0, opcode=0, ir_valid=0, byte_sel=0. Assert rst_n=0 asynchronously mid-cycle -> outputs clear without a clock edge.
- Two-byte fetch: ena=1; load_ir with data=8'hE1, then load_ir with data=8'h23 -> opcode=3'b111 (JMP), ir_addr=13'h0123, ir_valid=1 after the second edge, byte_sel toggles 0->1->0.
- Jump: following the previous case, load_pc=1 -> pc_addr=13'h0123. Drive load_pc=1 and inc_pc=1 together -> pc_addr=13'h0123 (load wins).
- Wrap: preload pc=13'h1FFF, pulse inc_pc -> pc_addr=0. Concurrent inc_pc with HI load_ir (data=8'hA0) -> pc increments and opcode=3'b101 on the same edge.
- Address mux: ir_addr=13'h0055, pc=13'h0010; fetch=1 -> addr=13'h0010; fetch=0 -> addr=13'h0055 with no clock edge.
- ena drop mid-instruction: after the HI byte (byte_sel=1), ena=0 for one cycle with load_ir=1 -> byte_sel=0, ir_valid=0, ir and pc unchanged. Restore ena; next load_ir writes the high byte.
